bus_transfer_controller: RTL
============================

# bus_transfer_controller

Sequencer for the shared 16-bit tri-state register bus. Accepts register-to-register (or external-to-register) move commands over a valid/ready handshake, buffers up to two, and executes each by driving one-hot source output-enables and destination set strobes in a fixed three-cycle DRIVE/LATCH/HOLD pattern. It is the only block allowed to drive the register file's `en`/`set` lines, so at most one bus driver is active in any cycle.

## Interface
- `NREGS`, 4: number of registers on the bus. Source index `NREGS` selects the external driver.
- `IDXW`, `$clog2(NREGS+1)`: width of the register index fields.

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command present.
- `cmd_src` input IDXW: source index, 0..NREGS. NREGS means external.
- `cmd_dst` input IDXW: destination index, 0..NREGS-1.
- `cmd_ready` output 1: controller can accept a command.
- `reg_en` output NREGS: one-hot or zero output-enables to register enablers.
- `ext_en` output 1: output-enable for the external bus driver.
- `reg_set` output NREGS: one-hot or zero set strobes to register memory cells.
- `busy` output 1: a transfer is in progress or the queue is non-empty.
- `done` output 1: one-cycle pulse marking completion of a transfer.
- `err` output 1: one-cycle pulse marking rejection of an illegal command.

## Operation
- **Handshake:** a command is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_ready = (queue count < 2)`, and it is combinational from the registered count.
- **Legality check at acceptance:**
  - Illegal if `cmd_dst >= NREGS`, `cmd_src > NREGS`, or `cmd_src == cmd_dst`.
  - An illegal command is consumed without being queued, and `err` pulses high in the following cycle.
- **Queue:** 2-entry FIFO of {src, dst}.
  - A push and a pop in the same cycle are both honoured.
  - Pushes are impossible when the queue is full.
- **FSM states:** IDLE, DRIVE, LATCH, HOLD. All outputs are registered.
  - IDLE: all strobes low. If the queue is non-empty, pop the head into the current-transfer register and go to DRIVE.
  - DRIVE: source enable high (`reg_en[src]`, or `ext_en` if src==NREGS). `reg_set` is 0. Go to LATCH.
  - LATCH: source enable high and `reg_set[dst]` high. Go to HOLD.
  - HOLD: source enable high, `reg_set` 0, `done`=1.
    - If the queue is non-empty, pop and go to DRIVE.
    - Otherwise go to IDLE.
- **Invariants:**
  - At most one of {`reg_en` bits, `ext_en`} is high in any cycle.
  - `reg_set` is never high without a source enable in the same cycle.
  - `reg_set[dst]` is never high while `reg_en[dst]` is high.
- `busy` = (state != IDLE) || (queue count != 0).

## Timing
- **Reset (async, `rst_n`=0):**
  - Outputs: `reg_en`=0, `ext_en`=0, `reg_set`=0, `done`=0, `err`=0, `busy`=0, `cmd_ready`=1.
  - State: IDLE, queue count=0.
  - Reset mid-transfer aborts immediately with outputs low in the same cycle; queued commands are discarded.
- **Latency:** command accepted at edge k with controller idle and queue empty:
  - DRIVE in cycle k+1, LATCH in k+2, HOLD (with `done`) in k+3.
  - Back in IDLE in k+4 if nothing is pending.
- **Back-to-back:** HOLD of transfer n is followed directly by DRIVE of transfer n+1.
  - Sustained throughput is one transfer per 3 cycles.
  - Source enables of consecutive transfers never overlap, because they fall in distinct registered cycles.
- A command pushed in the same cycle the queue head is popped (IDLE→DRIVE or HOLD→DRIVE) is accepted. `cmd_ready` stays high if the count stays < 2.
- `err` is independent of the FSM and can coincide with `done`.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-LATCH of transfer src=1,dst=2 → same cycle, `reg_en`=0, `reg_set`=0, `done`=0, `busy`=0, `cmd_ready`=1. After release, the pending transfer never completes.
- **Single move (NREGS=4):** cmd src=0,dst=3 at edge k → `reg_en`=0001 in k+1..k+3; `reg_set`=1000 only in k+2; `done` only in k+3; `busy` low in k+4. With registers attached, R3 equals the R0 value (e.g. 16'hA5C3).
- **External load:** cmd src=4,dst=1 → `ext_en`=1 for 3 cycles, `reg_en`=0 throughout, `reg_set`=0010 in the middle cycle. R1 captures bus value 16'h1234.
- **Queue full / back-to-back:** hold `cmd_valid` with three commands (0→1, 1→2, 2→3) from idle:
  - `cmd_ready` drops while two are queued.
  - Enables are 0001,0001,0001,0010,0010,0010,0100,0100,0100 with no gaps.
  - Exactly 3 `done` pulses.
  - Final result: R3 = original R0 through chained moves.
- **Illegal commands:** src=2,dst=2; src=0,dst=4; src=5,dst=0 → each gives an `err` pulse the next cycle, no strobes, `busy` stays 0.
- **One-hot invariant:** a random legal command stream of 1000 commands with random `cmd_valid` gaps → the checker never sees two active enables, `reg_set` without an enable, or `reg_set[i]` with `reg_en[i]`. `done` count equals the legal command count.

Source files
------------

// File: rtl/bus_transfer_controller_if.sv
// rtl/bus_transfer_controller_if.sv - command handshake and register-bus strobe bundle
//
// Groups the move-command handshake with the strobes that steer the shared
// 16-bit register bus.
//   cmd_valid/cmd_src/cmd_dst : move command from the requester
//   cmd_ready                 : controller can take a command this cycle
//   reg_en                    : one-hot (or zero) register output-enables
//   ext_en                    : external bus driver output-enable
//   reg_set                   : one-hot (or zero) register set strobes
//   busy/done/err             : status, done and err are one-cycle pulses
// The controller side uses modport slave, the requester/bench uses master.
interface bus_transfer_controller_if #(
  parameter int NREGS = 4,
  parameter int IDXW  = $clog2(NREGS + 1)
);
  logic             cmd_valid;
  logic [IDXW-1:0]  cmd_src;
  logic [IDXW-1:0]  cmd_dst;
  logic             cmd_ready;
  logic [NREGS-1:0] reg_en;
  logic             ext_en;
  logic [NREGS-1:0] reg_set;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, reg_en, ext_en, reg_set, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, reg_en, ext_en, reg_set, busy, done, err
  );
endinterface

// File: rtl/bus_transfer_controller.sv
// rtl/bus_transfer_controller.sv - sequencer for moves on the shared tri-state register bus
//
// Accepts move commands {src, dst}, buffers up to two in a FIFO and runs each
// as DRIVE / LATCH / HOLD: the source enable is high for all three cycles and
// the destination set strobe only in LATCH, so the bus is stable around the
// capture edge. Source NREGS is the external driver.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : command handshake and bus strobes (slave side)
// All outputs except cmd_ready are registered; cmd_ready decodes the
// registered queue count.
module bus_transfer_controller #(
  parameter int NREGS = 4,
  parameter int IDXW  = $clog2(NREGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bus_transfer_controller_if.slave bus
);

  localparam logic [IDXW-1:0] EXT_IDX = IDXW'(NREGS);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, HOLD} state_t;

  state_t state, state_next;

  // Two-entry command FIFO
  logic [IDXW-1:0] q_src [2];
  logic [IDXW-1:0] q_dst [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count, count_next;

  // Transfer currently on the bus
  logic [IDXW-1:0] cur_src, cur_dst, cur_src_next, cur_dst_next;

  logic accept, legal, push, can_take, take, fifo_push, fifo_pop, active;

  logic [NREGS-1:0] reg_en_next, reg_set_next;
  logic             ext_en_next, done_next, err_next, busy_next;

  assign bus.cmd_ready = (count < 2'd2);

  // Handshake, legality and queue bookkeeping
  always_comb begin
    accept   = bus.cmd_valid && bus.cmd_ready;
    legal    = (bus.cmd_dst < EXT_IDX) && (bus.cmd_src <= EXT_IDX) &&
               (bus.cmd_src != bus.cmd_dst);
    push     = accept && legal;
    can_take = (state == IDLE) || (state == HOLD);
    // An arriving command may be taken straight into the transfer register
    // when the FIFO is empty; this gives DRIVE in the cycle after acceptance.
    take      = can_take && ((count != 2'd0) || push);
    fifo_pop  = take && (count != 2'd0);
    fifo_push = push && !(take && (count == 2'd0));
    count_next = count + 2'(fifo_push) - 2'(fifo_pop);

    cur_src_next = cur_src;
    cur_dst_next = cur_dst;
    if (take) begin
      if (fifo_pop) begin
        cur_src_next = q_src[rd_ptr];
        cur_dst_next = q_dst[rd_ptr];
      end else begin
        cur_src_next = bus.cmd_src;
        cur_dst_next = bus.cmd_dst;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = take ? DRIVE : IDLE;
      DRIVE:   state_next = LATCH;
      LATCH:   state_next = HOLD;
      HOLD:    state_next = take ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered
  always_comb begin
    active       = (state_next != IDLE);
    reg_en_next  = '0;
    reg_set_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_en_next[i]  = active && (cur_src_next == IDXW'(i));
      reg_set_next[i] = (state_next == LATCH) && (cur_dst_next == IDXW'(i));
    end
    ext_en_next = active && (cur_src_next == EXT_IDX);
    done_next   = (state_next == HOLD);
    err_next    = accept && !legal;
    busy_next   = active || (count_next != 2'd0);
  end

  // Queue pointers, count and transfer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      cur_src <= '0;
      cur_dst <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop)  rd_ptr <= ~rd_ptr;
      count   <= count_next;
      cur_src <= cur_src_next;
      cur_dst <= cur_dst_next;
    end
  end

  // FIFO storage carries no control meaning, so it is left unreset
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      q_src[wr_ptr] <= bus.cmd_src;
      q_dst[wr_ptr] <= bus.cmd_dst;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.reg_en  <= '0;
      bus.ext_en  <= 1'b0;
      bus.reg_set <= '0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.reg_en  <= reg_en_next;
      bus.ext_en  <= ext_en_next;
      bus.reg_set <= reg_set_next;
      bus.done    <= done_next;
      bus.err     <= err_next;
      bus.busy    <= busy_next;
    end
  end

endmodule
